// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_timeout_counter.sv
// 6-bit BUSY-cycle counter with synchronous clear/enable; flags when the limit is reached.
module muldiv_timeout_counter #(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [5:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 6'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == 6'(TIMEOUT));

endmodule

// File: rtl/muldiv_sequencer.sv
// Issues one MULT/DIV to the shared units, holds operands, and returns the result on a
// valid/ready response port; stalls the pipeline via busy while an op is outstanding.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             busy,
    output logic             ctrl_MULT,
    output logic             ctrl_DIV,
    output logic [WIDTH-1:0] unit_operandA,
    output logic [WIDTH-1:0] unit_operandB,
    input  logic [WIDTH-1:0] mult_result,
    input  logic [WIDTH-1:0] div_result,
    input  logic             mult_exception,
    input  logic             div_exception,
    input  logic             mult_resultRDY,
    input  logic             div_resultRDY,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_exception,
    output logic [TAG_W-1:0] rsp_tag
);

    state_e             state_q, state_d;
    logic               op_q, op_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;

    logic               sel_rdy;
    logic               sel_exc;
    logic [WIDTH-1:0]   sel_result;
    logic               cnt_expired;

    muldiv_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state_q == S_START),
        .enable  (state_q == S_BUSY),
        .expired (cnt_expired)
    );

    // Only the unit that was started is listened to.
    assign sel_rdy    = (op_q == OP_DIV) ? div_resultRDY  : mult_resultRDY;
    assign sel_exc    = (op_q == OP_DIV) ? div_exception  : mult_exception;
    assign sel_result = (op_q == OP_DIV) ? div_result     : mult_result;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        div0_d   = div0_q;
        a_d      = a_q;
        b_d      = b_q;
        tag_d    = tag_q;
        result_d = result_q;
        exc_d    = exc_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    op_d     = req_op;
                    a_d      = req_a;
                    b_d      = req_b;
                    tag_d    = req_tag;
                    div0_d   = (req_op == OP_DIV) && (req_b == '0);
                    result_d = '0;
                    exc_d    = (req_op == OP_DIV) && (req_b == '0);
                    state_d  = S_START;
                end
            end
            // Divide-by-zero passes through START without a pulse and answers directly.
            S_START: state_d = div0_q ? S_DONE : S_BUSY;
            S_BUSY: begin
                if (sel_rdy) begin
                    result_d = sel_result;
                    exc_d    = sel_exc;
                    state_d  = S_DONE;
                end else if (cnt_expired) begin
                    result_d = '0;
                    exc_d    = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MULT;
            div0_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            div0_q   <= div0_d;
            a_q      <= a_d;
            b_q      <= b_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign req_ready     = (state_q == S_IDLE) && !flush;
    assign busy          = (state_q != S_IDLE);
    assign ctrl_MULT     = (state_q == S_START) && !flush && !div0_q && (op_q == OP_MULT);
    assign ctrl_DIV      = (state_q == S_START) && !flush && !div0_q && (op_q == OP_DIV);
    assign unit_operandA = a_q;
    assign unit_operandB = b_q;
    assign rsp_valid     = (state_q == S_DONE);
    assign rsp_result    = result_q;
    assign rsp_exception = exc_q;
    assign rsp_tag       = tag_q;

endmodule
